// File: rtl/prog_loader_if.sv
// Byte-stream link from the host into the program loader.
// A byte moves on a rising clock edge when in_valid && in_ready; in_ready never looks at in_valid.
interface prog_loader_if;
    logic       in_valid;
    logic [7:0] in_byte;
    logic       in_ready;

    modport master (output in_valid, output in_byte, input  in_ready);
    modport slave  (input  in_valid, input  in_byte, output in_ready);
endinterface

// File: rtl/prog_loader.sv
// Instruction RAM owner: zeroes the RAM, loads a counted little-endian program,
// and holds the processor in reset until the program is in place.
module prog_loader #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH),
    parameter int PC_W  = 16
) (
    input  logic            clk,
    input  logic            rst,
    prog_loader_if.slave    s_in,
    input  logic [PC_W-1:0] pc,
    output logic [15:0]     ins,
    output logic            cpu_rst,
    output logic            done,
    output logic            err,
    output logic [2:0]      dbg_state
);

    typedef enum logic [2:0] {
        S_CLEAR  = 3'd0,
        S_HDR_LO = 3'd1,
        S_HDR_HI = 3'd2,
        S_DAT_LO = 3'd3,
        S_DAT_HI = 3'd4,
        S_RUN    = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    localparam logic [16:0] DEPTH_W = 17'(DEPTH);

    state_t        r_state;
    logic [AW-1:0] r_addr;
    logic [15:0]   r_cnt;
    logic [7:0]    r_lo;
    logic [15:0]   r_mem [DEPTH];

    state_t        w_next_state;
    logic [AW-1:0] w_next_addr;
    logic [15:0]   w_next_cnt;
    logic [7:0]    w_next_lo;
    logic          w_we;
    logic [15:0]   w_wdata;
    logic          w_ready;
    logic          w_xfer;
    logic [15:0]   w_hdr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_CLEAR;
            r_addr  <= '0;
            r_cnt   <= '0;
            r_lo    <= '0;
        end else begin
            r_state <= w_next_state;
            r_addr  <= w_next_addr;
            r_cnt   <= w_next_cnt;
            r_lo    <= w_next_lo;
        end
    end

    // No reset on the array itself: the CLEAR sweep is what zeroes it.
    always_ff @(posedge clk) begin
        if (w_we && !rst) begin
            r_mem[r_addr] <= w_wdata;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_addr  = r_addr;
        w_next_cnt   = r_cnt;
        w_next_lo    = r_lo;
        w_we         = 1'b0;
        w_wdata      = 16'h0000;
        w_ready      = (r_state == S_HDR_LO) || (r_state == S_HDR_HI) ||
                       (r_state == S_DAT_LO) || (r_state == S_DAT_HI);
        w_xfer       = s_in.in_valid && w_ready;
        w_hdr        = {s_in.in_byte, r_cnt[7:0]};

        case (r_state)
            S_CLEAR: begin
                w_we = 1'b1;
                if (r_addr == AW'(DEPTH - 1)) begin
                    w_next_addr  = '0;
                    w_next_state = S_HDR_LO;
                end else begin
                    w_next_addr = r_addr + 1'b1;
                end
            end
            S_HDR_LO: begin
                if (w_xfer) begin
                    w_next_cnt   = {r_cnt[15:8], s_in.in_byte};
                    w_next_state = S_HDR_HI;
                end
            end
            S_HDR_HI: begin
                if (w_xfer) begin
                    w_next_cnt = w_hdr;
                    // The count check here is what keeps addr from ever wrapping.
                    if (w_hdr == 16'd0) begin
                        w_next_state = S_RUN;
                    end else if ({1'b0, w_hdr} > DEPTH_W) begin
                        w_next_state = S_ERR;
                    end else begin
                        w_next_state = S_DAT_LO;
                    end
                end
            end
            S_DAT_LO: begin
                if (w_xfer) begin
                    w_next_lo    = s_in.in_byte;
                    w_next_state = S_DAT_HI;
                end
            end
            S_DAT_HI: begin
                if (w_xfer) begin
                    w_we         = 1'b1;
                    w_wdata      = {s_in.in_byte, r_lo};
                    w_next_addr  = r_addr + 1'b1;
                    w_next_cnt   = r_cnt - 16'd1;
                    w_next_state = (r_cnt == 16'd1) ? S_RUN : S_DAT_LO;
                end
            end
            default: begin
                w_next_state = r_state;
            end
        endcase
    end

    assign s_in.in_ready = w_ready;
    assign ins           = r_mem[pc[AW-1:0]];
    assign cpu_rst       = (r_state != S_RUN);
    assign done          = (r_state == S_RUN);
    assign err           = (r_state == S_ERR);
    assign dbg_state     = r_state;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: directed load scenarios, a vector table for fetch reads,
// and randomized loads checked against an array model of the instruction RAM.
module tb_prog_loader;
    localparam int DEPTH = 1024;

    logic        clk;
    logic        rst;
    logic [15:0] pc;
    logic [15:0] ins;
    logic        cpu_rst;
    logic        done;
    logic        err;
    logic [2:0]  dbg_state;

    prog_loader_if bus ();

    prog_loader #(.DEPTH(DEPTH), .AW(10), .PC_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .s_in      (bus.slave),
        .pc        (pc),
        .ins       (ins),
        .cpu_rst   (cpu_rst),
        .done      (done),
        .err       (err),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] exp_ins;
    } vec_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] exp_mem [DEPTH];
    logic [15:0] g_words [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset(input bit valid_during_clear);
        int zeros;
        @(negedge clk);
        rst = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_cpu_rst",  32'(cpu_rst), 32'd1);
        check("rst_done",     32'(done), 32'd0);
        check("rst_err",      32'(err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        if (valid_during_clear) begin
            bus.in_valid = 1'b1;
            bus.in_byte  = 8'hFF;
        end
        zeros = 0;
        while (!bus.in_ready && zeros < 3000) begin
            zeros++;
            @(negedge clk);
        end
        check("clear_len", 32'(zeros), 32'(DEPTH));
        foreach (exp_mem[i]) exp_mem[i] = 16'h0000;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stall);
        int guard;
        if (stall) begin
            bus.in_valid = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        bus.in_valid = 1'b1;
        bus.in_byte  = b;
        guard = 0;
        while (!bus.in_ready && guard < 100) begin
            guard++;
            @(negedge clk);
        end
        if (guard >= 100) begin
            n_tests++;
            n_fail++;
            $display("FAIL ready_timeout: in_ready still %0b after %0d cycles, required 1", bus.in_ready, guard);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic check_mem(input string name);
        int errs;
        int first;
        logic [15:0] got;
        errs = 0;
        first = 0;
        got = '0;
        for (int i = 0; i < DEPTH; i++) begin
            pc = 16'(i);
            #1;
            if (ins !== exp_mem[i]) begin
                if (errs == 0) begin
                    first = i;
                    got = ins;
                end
                errs++;
            end
        end
        n_tests++;
        if (errs != 0) begin
            n_fail++;
            $display("FAIL %s: %0d bad words, first at %0d got %04h expected %04h",
                     name, errs, first, got, exp_mem[first]);
        end
        @(negedge clk);
    endtask

    // Sends header + g_words, then checks status and the full RAM image against the model.
    task automatic run_load(input string name, input int hdr, input bit stall);
        bit exp_err;
        int nw;
        exp_err = (hdr > DEPTH);
        nw = exp_err ? 0 : hdr;
        for (int i = 0; i < nw; i++) exp_mem[i] = g_words[i];

        send_byte(8'(hdr), stall);
        if (nw == 0) begin
            check({name, "_pre_cpu_rst"}, 32'(cpu_rst), 32'd1);
            send_byte(8'(hdr >> 8), stall);
        end else begin
            send_byte(8'(hdr >> 8), stall);
            for (int i = 0; i < nw; i++) begin
                send_byte(g_words[i][7:0], stall);
                if (i == nw - 1) begin
                    pc = 16'(i);
                    check({name, "_pre_cpu_rst"}, 32'(cpu_rst), 32'd1);
                    check({name, "_pre_done"}, 32'(done), 32'd0);
                end
                send_byte(g_words[i][15:8], stall);
            end
            check({name, "_last_word"}, 32'(ins), 32'(g_words[nw - 1]));
        end
        check({name, "_done"},    32'(done), 32'(!exp_err));
        check({name, "_err"},     32'(err), 32'(exp_err));
        check({name, "_cpu_rst"}, 32'(cpu_rst), 32'(exp_err));
        check({name, "_ready"},   32'(bus.in_ready), 32'd0);
        check_mem({name, "_mem"});
    endtask

    // Presents bytes in a terminal state; nothing may be consumed or change.
    task automatic hold_terminal(input string name, input bit exp_err);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            bus.in_byte = 8'($urandom_range(0, 255));
            @(negedge clk);
        end
        check({name, "_hold_ready"}, 32'(bus.in_ready), 32'd0);
        check({name, "_hold_done"},  32'(done), 32'(!exp_err));
        check({name, "_hold_err"},   32'(err), 32'(exp_err));
        bus.in_valid = 1'b0;
        check_mem({name, "_hold_mem"});
    endtask

    initial begin
        vec_t vecs [5];
        int   hdr;
        int   n;

        rst = 1'b1;
        pc = '0;
        bus.in_valid = 1'b0;
        bus.in_byte  = 8'h00;

        // Basic load
        do_reset(1'b0);
        g_words = '{16'h1234, 16'h5678, 16'h9ABC};
        run_load("basic", 3, 1'b0);
        vecs[0] = '{16'd0, 16'h1234};
        vecs[1] = '{16'd1, 16'h5678};
        vecs[2] = '{16'd2, 16'h9ABC};
        vecs[3] = '{16'd3, 16'h0000};
        vecs[4] = '{16'd1027, 16'h0000};
        for (int i = 0; i < 5; i++) begin
            pc = vecs[i].pc;
            #1;
            check($sformatf("basic_vec%0d", i), 32'(ins), 32'(vecs[i].exp_ins));
        end
        @(negedge clk);
        hold_terminal("basic", 1'b0);

        // Zero count
        do_reset(1'b0);
        g_words = {};
        run_load("zero", 0, 1'b0);

        // Oversize header
        do_reset(1'b0);
        run_load("over", 1025, 1'b0);
        hold_terminal("over", 1'b1);

        // Exact full
        do_reset(1'b0);
        g_words = {};
        for (int i = 0; i < DEPTH; i++) g_words.push_back(16'(i));
        run_load("full", DEPTH, 1'b0);
        hold_terminal("full", 1'b0);

        // Stalled load, with bytes offered during CLEAR
        do_reset(1'b1);
        g_words = {16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535))};
        run_load("stall", 2, 1'b1);

        // Reset mid-load
        do_reset(1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h44, 1'b0);
        do_reset(1'b0);
        g_words = {16'hBEEF};
        run_load("midrst", 1, 1'b0);
        pc = 16'd0;
        #1;
        check("midrst_ins0", 32'(ins), 32'h0000BEEF);
        pc = 16'd1;
        #1;
        check("midrst_ins1", 32'(ins), 32'h00000000);
        @(negedge clk);

        // Randomized loads
        for (int t = 0; t < 6; t++) begin
            case ($urandom_range(0, 5))
                0:       hdr = 0;
                1:       hdr = $urandom_range(DEPTH + 1, 65535);
                default: hdr = $urandom_range(1, 12);
            endcase
            n = (hdr > DEPTH) ? 0 : hdr;
            g_words = {};
            for (int i = 0; i < n; i++) g_words.push_back(16'($urandom_range(0, 65535)));
            do_reset(1'($urandom_range(0, 1)));
            run_load($sformatf("rand%0d", t), hdr, 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
